// File: rtl/dm_access_unit.sv
// Data-memory access controller between the CPU memory stage and a single-port RAM.
// Byte/half/word(/dword) loads with extension; sub-word stores by read-modify-write or byte enables.
module dm_access_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned USE_BE = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req,
    output logic                                  ready,
    input  logic                                  is_store,
    input  logic [1:0]                            size,
    input  logic                                  is_signed,
    input  logic [ADDR_W-1:0]                     addr,
    input  logic [DATA_W-1:0]                     wdata,
    output logic [DATA_W-1:0]                     rdata,
    output logic                                  done,
    output logic                                  err,
    output logic [ADDR_W-$clog2(DATA_W/8)-1:0]    mem_addr,
    output logic                                  mem_re,
    output logic                                  mem_we,
    output logic [DATA_W/8-1:0]                   mem_be,
    output logic [DATA_W-1:0]                     mem_wdata,
    input  logic [DATA_W-1:0]                     mem_rdata
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned LSB   = $clog2(BYTES);
    localparam int unsigned MW    = ADDR_W - LSB;
    localparam int unsigned SHW   = LSB + 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_WRITE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                st_q, sgn_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   merge_q, merge_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [LSB-1:0]      lane;
    logic [SHW-1:0]      shamt;
    logic                misaligned, full_width, load_neg;
    logic [BYTES-1:0]    size_mask, lane_mask;
    logic [DATA_W-1:0]   size_bits, lane_bits, wdata_sh, rdata_sh, load_ext;

    logic                done_c, err_c, re_c, we_c, ld_done_c;
    logic [BYTES-1:0]    be_c;
    logic [DATA_W-1:0]   wd_c;
    logic [MW-1:0]       addr_c;

    assign lane  = addr_q[LSB-1:0];
    assign shamt = {lane, 3'b000};

    // Access decode: lane coverage, alignment, lane-shifted store data, extended load data.
    always_comb begin
        size_mask  = '1;
        misaligned = 1'b0;
        load_neg   = 1'b0;
        size_bits  = '0;
        lane_bits  = '0;
        unique case (size_q)
            2'd0: size_mask = BYTES'(1);
            2'd1: size_mask = BYTES'(3);
            2'd2: size_mask = BYTES'(15);
            default: size_mask = '1;
        endcase
        unique case (size_q)
            2'd0: misaligned = 1'b0;
            2'd1: misaligned = addr_q[0];
            2'd2: misaligned = |addr_q[1:0];
            default: misaligned = (DATA_W == 32) ? 1'b1 : (|addr_q[2:0]);
        endcase
        full_width = &size_mask;
        lane_mask  = size_mask << lane;
        for (int k = 0; k < int'(BYTES); k++) begin
            size_bits[8*k +: 8] = {8{size_mask[k]}};
            lane_bits[8*k +: 8] = {8{lane_mask[k]}};
        end
        wdata_sh = (wdata_q & size_bits) << shamt;
        rdata_sh = mem_rdata >> shamt;
        unique case (size_q)
            2'd0: load_neg = rdata_sh[7];
            2'd1: load_neg = rdata_sh[15];
            2'd2: load_neg = rdata_sh[31];
            default: load_neg = rdata_sh[DATA_W-1];
        endcase
        load_neg = load_neg & sgn_q;
        load_ext = (rdata_sh & size_bits) | (load_neg ? ~size_bits : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            st_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            if (req && ready) begin
                st_q    <= is_store;
                sgn_q   <= is_signed;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    // Next state and per-state memory/handshake strobes.
    always_comb begin
        state_d   = state_q;
        merge_d   = merge_q;
        rdata_d   = rdata_q;
        done_c    = 1'b0;
        err_c     = 1'b0;
        re_c      = 1'b0;
        we_c      = 1'b0;
        ld_done_c = 1'b0;
        be_c      = '0;
        wd_c      = '0;
        addr_c    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                addr_c = addr_q[ADDR_W-1:LSB];
                if (misaligned) begin
                    done_c  = 1'b1;
                    err_c   = 1'b1;
                    state_d = ST_IDLE;
                end else if (st_q && (full_width || USE_BE != 0)) begin
                    we_c    = 1'b1;
                    be_c    = lane_mask;
                    wd_c    = wdata_sh;
                    done_c  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    re_c    = 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                addr_c = addr_q[ADDR_W-1:LSB];
                if (st_q) begin
                    merge_d = (mem_rdata & ~lane_bits) | (wdata_sh & lane_bits);
                    state_d = ST_WRITE;
                end else begin
                    rdata_d   = load_ext;
                    done_c    = 1'b1;
                    ld_done_c = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                addr_c  = addr_q[ADDR_W-1:LSB];
                we_c    = 1'b1;
                be_c    = '1;
                wd_c    = merge_q;
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are state decodes; reset squashes them so an in-flight op leaves no trace.
    assign ready     = (state_q == ST_IDLE) && !rst;
    assign done      = done_c && !rst;
    assign err       = err_c && !rst;
    assign mem_re    = re_c && !rst;
    assign mem_we    = we_c && !rst;
    assign mem_be    = rst ? '0 : be_c;
    assign mem_wdata = rst ? '0 : wd_c;
    assign mem_addr  = rst ? '0 : addr_c;
    assign rdata     = rst ? '0 : (ld_done_c ? load_ext : rdata_q);

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: RMW (USE_BE=0) and byte-enable (USE_BE=1) instances against a byte-level memory model.
module tb_dm_access_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req0, req1, is_store, is_signed;
    logic [1:0]  size;
    logic [9:0]  addr;
    logic [31:0] wdata;

    logic        ready0, done0, err0, mem_re0, mem_we0;
    logic        ready1, done1, err1, mem_re1, mem_we1;
    logic [31:0] rdata0, mem_wdata0, mem_rdata0;
    logic [31:0] rdata1, mem_wdata1, mem_rdata1;
    logic [7:0]  mem_addr0, mem_addr1;
    logic [3:0]  mem_be0, mem_be1;

    logic        init_we;
    logic [7:0]  init_a;
    logic [31:0] init_d;

    logic [31:0] ram0 [256];
    logic [31:0] ram1 [256];
    logic [31:0] ref_mem [256];

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] last_rd0, last_rd1, last_wd1;
    logic [3:0]  last_be1;

    dm_access_unit #(.DATA_W(32), .ADDR_W(10), .USE_BE(0)) u_rmw (
        .clk(clk), .rst(rst), .req(req0), .ready(ready0), .is_store(is_store), .size(size),
        .is_signed(is_signed), .addr(addr), .wdata(wdata), .rdata(rdata0), .done(done0), .err(err0),
        .mem_addr(mem_addr0), .mem_re(mem_re0), .mem_we(mem_we0), .mem_be(mem_be0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    dm_access_unit #(.DATA_W(32), .ADDR_W(10), .USE_BE(1)) u_be (
        .clk(clk), .rst(rst), .req(req1), .ready(ready1), .is_store(is_store), .size(size),
        .is_signed(is_signed), .addr(addr), .wdata(wdata), .rdata(rdata1), .done(done1), .err(err1),
        .mem_addr(mem_addr1), .mem_re(mem_re1), .mem_we(mem_we1), .mem_be(mem_be1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    // Synchronous single-port RAMs with byte enables and one-cycle read latency.
    always @(posedge clk) begin
        if (init_we) begin
            ram0[init_a] <= init_d;
            ram1[init_a] <= init_d;
        end
        if (mem_we0)
            for (int k = 0; k < 4; k++)
                if (mem_be0[k]) ram0[mem_addr0][8*k +: 8] <= mem_wdata0[8*k +: 8];
        if (mem_re0) mem_rdata0 <= ram0[mem_addr0];
        if (mem_we1)
            for (int k = 0; k < 4; k++)
                if (mem_be1[k]) ram1[mem_addr1][8*k +: 8] <= mem_wdata1[8*k +: 8];
        if (mem_re1) mem_rdata1 <= ram1[mem_addr1];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic bit f_mis(input logic [1:0] sz, input logic [9:0] a);
        case (sz)
            2'd0: return 1'b0;
            2'd1: return a[0];
            2'd2: return a[1:0] != 2'd0;
            default: return 1'b1;
        endcase
    endfunction

    // Reference load: pick 2^sz bytes starting at the byte offset, then extend.
    function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] sz,
                                           input bit sg, input logic [9:0] a);
        int nb = 1 << sz;
        logic [63:0] v, m;
        v = 64'(w) >> (8 * int'(a[1:0]));
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = v & m;
        if (sg && v[8*nb-1]) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic logic [31:0] f_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [9:0] a, input logic [31:0] wd);
        logic [31:0] r = w;
        for (int i = 0; i < (1 << sz); i++) r[8*(int'(a[1:0]) + i) +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic do_op(input bit en0, input bit en1, input bit st, input logic [1:0] sz,
                         input bit sg, input logic [9:0] a, input logic [31:0] wd, input bit busy);
        bit          mis = f_mis(sz, a);
        int          idx = int'(a[9:2]);
        logic [31:0] exp_word = ref_mem[idx];
        logic [31:0] exp_rd = f_load(ref_mem[idx], sz, sg, a);
        int          lat0 = 0, lat1 = 0, nre0 = 0, nre1 = 0, nwe0 = 0, nwe1 = 0;
        logic        e0 = 1'b0, e1 = 1'b0;
        logic [31:0] rd0 = '0, rd1 = '0;
        int          xlat0, xlat1;
        if (!mis && st) exp_word = f_store(ref_mem[idx], sz, a, wd);
        xlat0 = mis ? 1 : (st ? ((sz == 2'd2) ? 1 : 3) : 2);
        xlat1 = mis ? 1 : (st ? 1 : 2);
        @(negedge clk);
        if (en0) chk("ready0", ready0, 1);
        if (en1) chk("ready1", ready1, 1);
        is_store = st; size = sz; is_signed = sg; addr = a; wdata = wd;
        req0 = en0; req1 = en1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (busy && c <= 2) begin
                req0 = 1'b1; addr = a ^ 10'h3c4; wdata = ~wd;
            end else begin
                req0 = 1'b0;
            end
            req1 = 1'b0;
            if (mem_re0) nre0++;
            if (mem_we0) nwe0++;
            if (mem_re1) nre1++;
            if (mem_we1) begin nwe1++; last_be1 = mem_be1; last_wd1 = mem_wdata1; end
            if (done0 && lat0 == 0) begin lat0 = c; e0 = err0; rd0 = rdata0; end
            if (done1 && lat1 == 0) begin lat1 = c; e1 = err1; rd1 = rdata1; end
        end
        if (en0) begin
            if (!st && !mis) last_rd0 = exp_rd;
            chk("lat0", 64'(lat0), 64'(xlat0));
            chk("err0", e0, mis);
            chk("reads0", 64'(nre0), 64'((!mis && (!st || sz != 2'd2)) ? 1 : 0));
            chk("writes0", 64'(nwe0), 64'((!mis && st) ? 1 : 0));
            chk("rdata0", rd0, last_rd0);
            chk("word0", ram0[idx], exp_word);
        end
        if (en1) begin
            if (!st && !mis) last_rd1 = exp_rd;
            chk("lat1", 64'(lat1), 64'(xlat1));
            chk("err1", e1, mis);
            chk("reads1", 64'(nre1), 64'((!mis && !st) ? 1 : 0));
            chk("writes1", 64'(nwe1), 64'((!mis && st) ? 1 : 0));
            chk("rdata1", rd1, last_rd1);
            chk("word1", ram1[idx], exp_word);
        end
        ref_mem[idx] = exp_word;
    endtask

    initial begin
        logic [1:0]  sz;
        logic [9:0]  a;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; is_store = 1'b0; size = 2'd0; is_signed = 1'b0;
        addr = '0; wdata = '0; init_we = 1'b0; init_a = '0; init_d = '0;
        last_rd0 = '0; last_rd1 = '0; last_be1 = '0; last_wd1 = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            init_we = 1'b1;
            init_a  = 8'(i);
            init_d  = (i == 5) ? 32'h1122_3344 : (i == 8) ? 32'h80FF_7F01 : $urandom;
            ref_mem[i] = init_d;
        end
        @(negedge clk);
        init_we = 1'b0;
        chk("rst_ctl0", {ready0, done0, err0, mem_re0, mem_we0, mem_be0}, 0);
        chk("rst_dat0", {mem_addr0, mem_wdata0}, 0);
        chk("rst_ctl1", {ready1, done1, err1, mem_re1, mem_we1, mem_be1}, 0);
        chk("rst_rdata", {rdata0, rdata1}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {ready0, ready1}, 2'b11);
        chk("idle_outs", {done0, err0, mem_re0, mem_we0, mem_be0, mem_addr0, mem_wdata0}, 0);

        do_op(1, 1, 1, 2'd0, 0, 10'h015, 32'h0000_00AB, 0);
        chk("sb_rmw_word", ram0[5], 32'h1122_AB44);
        do_op(1, 1, 1, 2'd1, 0, 10'h016, 32'h0000_BEEF, 0);
        chk("sh_be_mask", last_be1, 4'b1100);
        chk("sh_be_data", last_wd1[31:16], 16'hBEEF);
        chk("sh_word", ram1[5], 32'hBEEF_AB44);
        do_op(1, 1, 0, 2'd0, 1, 10'h022, 32'h0, 0);
        chk("lb", last_rd0, 32'hFFFF_FFFF);
        do_op(1, 1, 0, 2'd0, 0, 10'h022, 32'h0, 0);
        chk("lbu", last_rd0, 32'h0000_00FF);
        do_op(1, 1, 0, 2'd1, 1, 10'h022, 32'h0, 0);
        chk("lh", last_rd1, 32'hFFFF_80FF);
        do_op(1, 1, 0, 2'd2, 1, 10'h020, 32'h0, 0);
        chk("lw", last_rd0, 32'h80FF_7F01);
        do_op(1, 1, 0, 2'd1, 1, 10'h003, 32'h0, 0);
        do_op(1, 1, 1, 2'd2, 0, 10'h002, 32'h1234_5678, 0);
        do_op(1, 1, 0, 2'd3, 0, 10'h000, 32'h0, 0);
        do_op(1, 0, 1, 2'd0, 0, 10'h011, 32'h0000_0077, 1);
        do_op(0, 1, 1, 2'd0, 0, 10'h011, 32'h0000_0077, 0);

        // Reset lands in the WRITE cycle of an RMW byte store.
        @(negedge clk);
        is_store = 1'b1; size = 2'd0; is_signed = 1'b0; addr = 10'h015; wdata = 32'h5A; req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        chk("rw_read", mem_re0, 1);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rw_we_gated", mem_we0, 0);
        chk("rw_no_done", done0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rw_ram", ram0[5], ref_mem[5]);
        chk("rw_rdata", {rdata0, rdata1}, 0);
        chk("rw_ready", ready0, 1);
        last_rd0 = '0;
        last_rd1 = '0;

        for (int n = 0; n < 200; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 10'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a = a & ~10'((1 << sz) - 1);
            do_op(1, 1, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 0);
        end

        for (int i = 0; i < 16; i++) begin
            chk("final_ram0", ram0[i], ref_mem[i]);
            chk("final_ram1", ram1[i], ref_mem[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
